// File: rtl/threewire_target.sv
// Responder end of the three-wire serial link: oversamples CS/clock/data on in_clk and
// presents decoded frames as a register-bus handshake. Optional: TW_TARGET_ABORT_CNT_EN.
module threewire_target #(
  parameter int ADDR_BITS   = 9,
  parameter int DATA_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_tw_clock,
  input  logic                 in_tw_cs,
  inout  logic                 io_tw_data,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [DATA_BITS-1:0] out_wr_data,
  output logic                 out_wr_strobe,
  output logic                 out_rd_req,
  input  logic [DATA_BITS-1:0] in_rd_data,
  output logic                 out_busy
`ifdef TW_TARGET_ABORT_CNT_EN
  ,
  output logic                 out_abort,
  output logic [7:0]           out_abort_cnt
`endif
);

  localparam int CNT_W = $clog2((ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RW      = 3'd1;
  localparam logic [2:0] ST_ADDR    = 3'd2;
  localparam logic [2:0] ST_WR_DATA = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, dat_sync;
  logic                   clk_prev, cs_prev;
  logic                   clk_s, cs_s, data_s;
  logic                   clk_rise, clk_fall, cs_rise, cs_fall;
  logic                   frame_abort;

  logic [2:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic                   is_write;
  logic                   rd_started;
  logic                   tw_oe;
  logic [ADDR_BITS-2:0]   addr_sr;
  logic [DATA_BITS-2:0]   wr_sr;
  logic [DATA_BITS-1:0]   rd_sr;

  // CS synchroniser resets low so a frame already in progress at reset release is ignored
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      clk_sync <= '0;
      cs_sync  <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
      cs_prev  <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], in_tw_clock};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], in_tw_cs};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], io_tw_data};
      clk_prev <= clk_s;
      cs_prev  <= cs_s;
    end
  end

  assign clk_s       = clk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign data_s      = dat_sync[SYNC_STAGES-1];
  assign clk_rise    = clk_s & ~clk_prev;
  assign clk_fall    = ~clk_s & clk_prev;
  assign cs_rise     = cs_s & ~cs_prev;
  assign cs_fall     = ~cs_s & cs_prev;
  assign frame_abort = cs_rise && (state != ST_IDLE) && (state != ST_DONE);

  assign io_tw_data = tw_oe ? rd_sr[DATA_BITS-1] : 1'bz;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      is_write      <= 1'b0;
      rd_started    <= 1'b0;
      tw_oe         <= 1'b0;
      addr_sr       <= '0;
      wr_sr         <= '0;
      rd_sr         <= '0;
      out_addr      <= '0;
      out_wr_data   <= '0;
      out_wr_strobe <= 1'b0;
      out_rd_req    <= 1'b0;
      out_busy      <= 1'b0;
    end else begin
      out_wr_strobe <= 1'b0;
      out_rd_req    <= 1'b0;
      // CS rise takes priority over any clock edge seen in the same cycle
      if (frame_abort || (cs_rise && state == ST_DONE)) begin
        state    <= ST_IDLE;
        out_busy <= 1'b0;
        tw_oe    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state    <= ST_RW;
              out_busy <= 1'b1;
              cnt      <= '0;
            end
          end
          ST_RW: begin
            if (clk_rise) begin
              is_write <= data_s;
              cnt      <= CNT_W'(ADDR_BITS - 1);
              state    <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (clk_rise) begin
              addr_sr <= {addr_sr[ADDR_BITS-3:0], data_s};
              if (cnt == '0) begin
                out_addr   <= {addr_sr, data_s};
                rd_started <= 1'b0;
                if (is_write) begin
                  cnt   <= CNT_W'(DATA_BITS - 1);
                  state <= ST_WR_DATA;
                end else begin
                  out_rd_req <= 1'b1;
                  state      <= ST_RD_DATA;
                end
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
          ST_WR_DATA: begin
            if (clk_rise) begin
              wr_sr <= {wr_sr[DATA_BITS-3:0], data_s};
              if (cnt == '0) begin
                out_wr_data   <= {wr_sr, data_s};
                out_wr_strobe <= 1'b1;
                state         <= ST_DONE;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
          ST_RD_DATA: begin
            if (clk_fall) begin
              if (!rd_started) begin
                rd_started <= 1'b1;
                rd_sr      <= in_rd_data;
                tw_oe      <= 1'b1;
                cnt        <= CNT_W'(DATA_BITS - 1);
              end else if (cnt == '0) begin
                tw_oe <= 1'b0;
                state <= ST_DONE;
              end else begin
                rd_sr <= {rd_sr[DATA_BITS-2:0], 1'b0};
                cnt   <= cnt - 1'b1;
              end
            end
          end
          ST_DONE: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef TW_TARGET_ABORT_CNT_EN
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_abort     <= 1'b0;
      out_abort_cnt <= '0;
    end else begin
      out_abort <= frame_abort;
      if (frame_abort && out_abort_cnt != 8'hFF) begin
        out_abort_cnt <= out_abort_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_threewire_target.sv
// Directed bench for threewire_target: table of write/read frames plus abort,
// extra-clock and mid-frame-reset sequences driven from a behavioural link master.
module tb_threewire_target;

  localparam int H = 100;

  logic        clk;
  logic        rst_n;
  logic        tw_clk;
  logic        tw_cs;
  logic        m_oe;
  logic        m_dout;
  wire         tw_data;
  logic [8:0]  out_addr;
  logic [15:0] out_wr_data;
  logic        out_wr_strobe;
  logic        out_rd_req;
  logic [15:0] in_rd_data;
  logic        out_busy;
`ifdef TW_TARGET_ABORT_CNT_EN
  logic        out_abort;
  logic [7:0]  out_abort_cnt;
`endif

  assign tw_data = m_oe ? m_dout : 1'bz;

  threewire_target #(
    .ADDR_BITS   (9),
    .DATA_BITS   (16),
    .SYNC_STAGES (2)
  ) dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_tw_clock   (tw_clk),
    .in_tw_cs      (tw_cs),
    .io_tw_data    (tw_data),
    .out_addr      (out_addr),
    .out_wr_data   (out_wr_data),
    .out_wr_strobe (out_wr_strobe),
    .out_rd_req    (out_rd_req),
    .in_rd_data    (in_rd_data),
    .out_busy      (out_busy)
`ifdef TW_TARGET_ABORT_CNT_EN
    ,
    .out_abort     (out_abort),
    .out_abort_cnt (out_abort_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int oe_cycles = 0;
  int abort_pulses = 0;

  always @(negedge clk) begin
    if (out_wr_strobe) wr_pulses++;
    if (out_rd_req) rd_pulses++;
    if (dut.tw_oe) oe_cycles++;
`ifdef TW_TARGET_ABORT_CNT_EN
    if (out_abort) abort_pulses++;
`endif
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    m_dout = b;
    #H tw_clk = 1'b1;
    #H tw_clk = 1'b0;
  endtask

  task automatic do_frame(input logic rw, input logic [8:0] addr, input logic [15:0] wdata,
                          input int extra, output logic [15:0] rval);
    rval  = '0;
    m_oe  = 1'b1;
    tw_cs = 1'b0;
    bit_out(rw);
    chk("busy_in_frame", 32'(out_busy), 32'd1);
    for (int i = 8; i >= 0; i--) begin
      if (i == 0 && !rw) begin
        m_dout = addr[0];
        #H tw_clk = 1'b1;
        #(H - 20);
        chk("no_drive_before_fall", 32'(dut.tw_oe), 32'd0);
        #20 tw_clk = 1'b0;
      end else begin
        bit_out(addr[i]);
      end
    end
    if (rw) begin
      for (int i = 15; i >= 0; i--) bit_out(wdata[i]);
      m_oe = 1'b0;
    end else begin
      m_oe = 1'b0;
      for (int j = 0; j < 16; j++) begin
        #H tw_clk = 1'b1;
        rval[15-j] = tw_data;
        #H tw_clk = 1'b0;
      end
      #H;
      chk("rd_release", 32'(dut.tw_oe), 32'd0);
    end
    repeat (extra) begin
      #H tw_clk = 1'b1;
      #H tw_clk = 1'b0;
    end
    #H tw_cs = 1'b1;
    #H;
    chk("busy_after_frame", 32'(out_busy), 32'd0);
    #H;
  endtask

  typedef struct {
    logic        rw;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          extra;
    int          exp_wr;
    int          exp_rd;
    logic [8:0]  exp_addr;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w0, r0, o0, a0;
    logic [15:0] rv;
    logic [8:0] ab_addr;

    vecs[0] = '{1'b1, 9'h0A5, 16'hBEEF, 16'h0000, 0, 1, 0, 9'h0A5, 16'hBEEF};
    vecs[1] = '{1'b0, 9'h1FF, 16'h0000, 16'h1234, 0, 0, 1, 9'h1FF, 16'h1234};
    vecs[2] = '{1'b1, 9'h100, 16'h8001, 16'h0000, 0, 1, 0, 9'h100, 16'h8001};
    vecs[3] = '{1'b0, 9'h000, 16'h0000, 16'hFFFF, 0, 0, 1, 9'h000, 16'hFFFF};
    vecs[4] = '{1'b1, 9'h155, 16'hA5A5, 16'h0000, 4, 1, 0, 9'h155, 16'hA5A5};
    vecs[5] = '{1'b0, 9'h0AA, 16'h0000, 16'h0001, 2, 0, 1, 9'h0AA, 16'h0001};

    rst_n = 1'b0;
    tw_clk = 1'b0;
    tw_cs = 1'b1;
    m_oe = 1'b0;
    m_dout = 1'b0;
    in_rd_data = '0;
    #2;
    #50;
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_wr_data", 32'(out_wr_data), 32'd0);
    chk("rst_strobe", 32'(out_wr_strobe), 32'd0);
    chk("rst_rd_req", 32'(out_rd_req), 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_oe", 32'(dut.tw_oe), 32'd0);
    rst_n = 1'b1;
    #H;

    for (int k = 0; k < 6; k++) begin
      w0 = wr_pulses; r0 = rd_pulses; o0 = oe_cycles;
      in_rd_data = vecs[k].rdata;
      do_frame(vecs[k].rw, vecs[k].addr, vecs[k].wdata, vecs[k].extra, rv);
      chk("wr_strobes", 32'(wr_pulses - w0), 32'(vecs[k].exp_wr));
      chk("rd_reqs", 32'(rd_pulses - r0), 32'(vecs[k].exp_rd));
      chk("addr", 32'(out_addr), 32'(vecs[k].exp_addr));
      if (vecs[k].rw) begin
        chk("wr_data", 32'(out_wr_data), 32'(vecs[k].exp_val));
        chk("no_drive_on_write", 32'(oe_cycles - o0), 32'd0);
      end else begin
        chk("rd_value", 32'(rv), 32'(vecs[k].exp_val));
      end
    end

    // Abort after 5 address bits of a write to 0x1C3
    w0 = wr_pulses; r0 = rd_pulses; a0 = abort_pulses;
    ab_addr = 9'h1C3;
    m_oe = 1'b1;
    tw_cs = 1'b0;
    bit_out(1'b1);
    for (int i = 8; i >= 4; i--) bit_out(ab_addr[i]);
    m_oe = 1'b0;
    #H tw_cs = 1'b1;
    #H;
    chk("abort_busy", 32'(out_busy), 32'd0);
    chk("abort_oe", 32'(dut.tw_oe), 32'd0);
    chk("abort_strobes", 32'(wr_pulses - w0), 32'd0);
    chk("abort_reqs", 32'(rd_pulses - r0), 32'd0);
    chk("abort_addr_kept", 32'(out_addr), 32'h0AA);
    chk("abort_data_kept", 32'(out_wr_data), 32'hA5A5);
`ifdef TW_TARGET_ABORT_CNT_EN
    chk("abort_pulse", 32'(abort_pulses - a0), 32'd1);
    chk("abort_cnt", 32'(out_abort_cnt), 32'd1);
`endif
    #H;

    // Reset asserted while read data bit 7 is on the wire
    in_rd_data = 16'h5A5A;
    ab_addr = 9'h0F0;
    m_oe = 1'b1;
    tw_cs = 1'b0;
    bit_out(1'b0);
    for (int i = 8; i >= 0; i--) bit_out(ab_addr[i]);
    m_oe = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #H tw_clk = 1'b1;
      #H tw_clk = 1'b0;
    end
    #(H / 2);
    chk("rd_driving_bit7", 32'(dut.tw_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_oe", 32'(dut.tw_oe), 32'd0);
    chk("midrst_busy", 32'(out_busy), 32'd0);
    chk("midrst_addr", 32'(out_addr), 32'd0);
    chk("midrst_wr_data", 32'(out_wr_data), 32'd0);
    chk("midrst_rd_req", 32'(out_rd_req), 32'd0);
`ifdef TW_TARGET_ABORT_CNT_EN
    chk("midrst_abort_cnt", 32'(out_abort_cnt), 32'd0);
`endif
    tw_cs = 1'b1;
    #H rst_n = 1'b1;
    #H;
    w0 = wr_pulses;
    do_frame(1'b1, 9'h033, 16'hC3C3, 0, rv);
    chk("post_rst_strobes", 32'(wr_pulses - w0), 32'd1);
    chk("post_rst_addr", 32'(out_addr), 32'h033);
    chk("post_rst_wr_data", 32'(out_wr_data), 32'hC3C3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
